exec_sequencer: RTL and testbench

//  Execute-stage controller directly upstream of the ALU. It accepts one instruction per handshake and holds a
//  4-entry register file. It presents operands and OP to the ALU, writes ALU_OUT back to the destination register,
//  and keeps an architectural zero flag. The ALU itself stays purely combinational; this block owns all state.

---
 rtl/exec_sequencer.sv | 145 ++++++++++++++
 tb/tb_exec_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Execute-stage controller upstream of a combinational ALU.
// Accepts one instruction per handshake, owns a small register file and the
// architectural zero flag, and retires each instruction in four cycles.
module exec_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4,
  parameter int REG_ADDR_W = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  input  logic [OP_WIDTH-1:0]   INSTR_OP,
  input  logic [REG_ADDR_W-1:0] INSTR_RD,
  input  logic [REG_ADDR_W-1:0] INSTR_RS,
  input  logic [DATA_WIDTH-1:0] INSTR_IMM,
  input  logic                  INSTR_USE_IMM,
  output logic [DATA_WIDTH-1:0] ALU_IN0,
  output logic [DATA_WIDTH-1:0] ALU_IN1,
  output logic [OP_WIDTH-1:0]   ALU_OP,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_ZF,
  output logic                  DONE,
  output logic                  ILLEGAL,
  output logic                  Z,
  input  logic [REG_ADDR_W-1:0] DBG_SEL,
  output logic [DATA_WIDTH-1:0] DBG_DATA
);

  localparam int NREGS = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_EXEC,
    S_WB
  } state_t;

  state_t                  state_q, state_d;
  logic [OP_WIDTH-1:0]     op_q, op_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_WIDTH-1:0]   in0_q, in0_d;
  logic [DATA_WIDTH-1:0]   in1_q, in1_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic                    zf_q, zf_d;
  logic                    z_q, z_d;
  logic [DATA_WIDTH-1:0]   regs_q [NREGS];
  logic [DATA_WIDTH-1:0]   regs_d [NREGS];

  // Opcode classes for the retiring instruction.
  logic op_alu_z;   // ALU result written back, zero flag updated
  logic op_self;    // RD rewritten with its own value
  logic op_move;    // RD <= IN1
  logic op_illegal; // no write, flagged

  // Decode the opcode held in the operand register.
  always_comb begin
    op_alu_z   = (op_q < OP_WIDTH'(10)) || (op_q == OP_WIDTH'(12));
    op_self    = (op_q == OP_WIDTH'(10));
    op_move    = (op_q == OP_WIDTH'(11));
    op_illegal = (op_q > OP_WIDTH'(12));
  end

  // Next-state, operand capture, result sampling and write-back.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    in0_d   = in0_q;
    in1_d   = in1_q;
    res_d   = res_q;
    zf_d    = zf_q;
    z_d     = z_q;
    regs_d  = regs_q;
    unique case (state_q)
      S_IDLE: begin
        if (INSTR_VALID) begin
          op_d    = INSTR_OP;
          rd_d    = INSTR_RD;
          in0_d   = regs_q[INSTR_RD];
          in1_d   = INSTR_USE_IMM ? INSTR_IMM : regs_q[INSTR_RS];
          state_d = S_LATCH;
        end
      end
      S_LATCH: state_d = S_EXEC;
      S_EXEC: begin
        res_d   = ALU_OUT;
        zf_d    = ALU_ZF;
        state_d = S_WB;
      end
      S_WB: begin
        if (op_alu_z) begin
          regs_d[rd_q] = res_q;
          z_d          = zf_q;
        end else if (op_self) begin
          regs_d[rd_q] = in0_q;
        end else if (op_move) begin
          regs_d[rd_q] = in1_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and blocks write-back.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      in0_q   <= '0;
      in1_q   <= '0;
      res_q   <= '0;
      zf_q    <= 1'b0;
      z_q     <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
      res_q   <= res_d;
      zf_q    <= zf_d;
      z_q     <= z_d;
      regs_q  <= regs_d;
    end
  end

  // Outputs derived from registered state only (DBG_DATA is a plain read port).
  always_comb begin
    INSTR_READY = (state_q == S_IDLE);
    DONE        = (state_q == S_WB);
    ILLEGAL     = (state_q == S_WB) && op_illegal;
    ALU_IN0     = in0_q;
    ALU_IN1     = in1_q;
    ALU_OP      = op_q;
    Z           = z_q;
    DBG_DATA    = regs_q[DBG_SEL];
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: a combinational ALU stand-in, a
// transaction-level reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic with occasional resets.
module tb_exec_sequencer;

  localparam int DW = 8;
  localparam int OW = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [OW-1:0] instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs;
  logic [DW-1:0] instr_imm;
  logic          instr_use_imm;
  logic [DW-1:0] alu_in0;
  logic [DW-1:0] alu_in1;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_out;
  logic          alu_zf;
  logic          done;
  logic          illegal;
  logic          z;
  logic [AW-1:0] dbg_sel;
  logic [DW-1:0] dbg_data;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  exec_sequencer #(
    .DATA_WIDTH(DW),
    .OP_WIDTH  (OW),
    .REG_ADDR_W(AW)
  ) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .INSTR_VALID  (instr_valid),
    .INSTR_READY  (instr_ready),
    .INSTR_OP     (instr_op),
    .INSTR_RD     (instr_rd),
    .INSTR_RS     (instr_rs),
    .INSTR_IMM    (instr_imm),
    .INSTR_USE_IMM(instr_use_imm),
    .ALU_IN0      (alu_in0),
    .ALU_IN1      (alu_in1),
    .ALU_OP       (alu_op),
    .ALU_OUT      (alu_out),
    .ALU_ZF       (alu_zf),
    .DONE         (done),
    .ILLEGAL      (illegal),
    .Z            (z),
    .DBG_SEL      (dbg_sel),
    .DBG_DATA     (dbg_data)
  );

  // ALU stand-in. Ops the sequencer handles itself return a scrambled value
  // so a write-back that wrongly takes ALU_OUT for them is visible.
  function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a & b;
      4'd2:    r = a | b;
      4'd3:    r = a ^ b;
      4'd4:    r = a - b;
      4'd5:    r = a << 1;
      4'd6:    r = a >> 1;
      4'd7:    r = ~a;
      4'd8:    r = a - 8'd1;
      4'd9:    r = a + 8'd1;
      4'd12:   r = b - a;
      default: r = a ^ b ^ 8'h3C;
    endcase
    return r;
  endfunction

  assign alu_out = alu_f(alu_op, alu_in0, alu_in1);
  assign alu_zf  = (alu_out == 8'h00);

  // Reference model: architectural registers plus one in-flight instruction
  // that retires three edges after it is accepted.
  logic [DW-1:0] m_regs [4];
  logic          m_z    = 1'b0;
  logic          m_busy = 1'b0;
  int            m_age  = 0;
  logic [OW-1:0] m_op   = '0;
  logic [AW-1:0] m_rd   = '0;
  logic [DW-1:0] m_in0  = '0;
  logic [DW-1:0] m_in1  = '0;
  logic          m_live = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      m_z = 1'b0; m_busy = 1'b0; m_age = 0;
      m_op = '0; m_rd = '0; m_in0 = '0; m_in1 = '0;
      m_live = 1'b1;
    end else if (m_busy) begin
      if (m_age == 2) begin
        if (m_op <= 4'd9 || m_op == 4'd12) begin
          m_regs[m_rd] = alu_f(m_op, m_in0, m_in1);
          m_z = (m_regs[m_rd] == 8'h00);
        end else if (m_op == 4'd10) begin
          m_regs[m_rd] = m_in0;
        end else if (m_op == 4'd11) begin
          m_regs[m_rd] = m_in1;
        end
        m_busy = 1'b0;
      end else begin
        m_age = m_age + 1;
      end
    end else if (instr_valid) begin
      m_op   = instr_op;
      m_rd   = instr_rd;
      m_in0  = m_regs[instr_rd];
      m_in1  = instr_use_imm ? instr_imm : m_regs[instr_rs];
      m_busy = 1'b1;
      m_age  = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("ready",   int'(instr_ready), int'(!m_busy));
      chk("done",    int'(done),        int'(m_busy && m_age == 2));
      chk("illegal", int'(illegal),     int'(m_busy && m_age == 2 && m_op >= 4'd13));
      chk("z",       int'(z),           int'(m_z));
      chk("alu_in0", int'(alu_in0),     int'(m_in0));
      chk("alu_in1", int'(alu_in1),     int'(m_in1));
      chk("alu_op",  int'(alu_op),      int'(m_op));
      chk("dbg",     int'(dbg_data),    int'(m_regs[dbg_sel]));
    end
  end

  // Drive fields; caller is #1 after an edge.
  task automatic present(input int op, input int rd, input int rs, input int imm, input int use_imm);
    instr_op      = OW'(op);
    instr_rd      = AW'(rd);
    instr_rs      = AW'(rs);
    instr_imm     = DW'(imm);
    instr_use_imm = use_imm[0];
    instr_valid   = 1'b1;
  endtask

  // Wait for the accepting edge, bounded; returns #1 after it, valid still high.
  task automatic accept(output int t_acc);
    bit ok = 0;
    t_acc = -1;
    for (int i = 0; i < 16; i++) begin
      if (instr_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
      t_acc = cyc;
    end else begin
      chk_cnt++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within 16 cycles");
    end
  endtask

  task automatic send(input int op, input int rd, input int rs, input int imm, input int use_imm);
    int t;
    present(op, rd, rs, imm, use_imm);
    accept(t);
    instr_valid = 1'b0;
  endtask

  // Called in the cycle after acceptance; lat is the cycle index of DONE relative to the accept edge.
  task automatic wait_done(output int lat, output logic ill, input bit junk);
    bit ok = 0;
    lat = 1;
    ill = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin ok = 1; ill = illegal; instr_valid = 1'b0; break; end
      if (junk) begin
        instr_valid   = 1'($urandom_range(0, 1));
        instr_op      = OW'($urandom);
        instr_rd      = AW'($urandom);
        instr_rs      = AW'($urandom);
        instr_imm     = DW'($urandom);
        instr_use_imm = 1'($urandom_range(0, 1));
        dbg_sel       = AW'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    instr_valid = 1'b0;
    if (!ok) begin
      chk_cnt++;
      $display("FAIL done_timeout: got done=0 expected done=1 within 8 cycles");
    end
  endtask

  task automatic check_reg(input int idx, input int exp, input string name);
    dbg_sel = AW'(idx);
    #1;
    chk(name, int'(dbg_data), exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int   lat, t1, t2;
    logic ill;
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs = '0;
    instr_imm = '0; instr_use_imm = 1'b0; dbg_sel = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_ready", int'(instr_ready), 1);
    chk("rst_done",  int'(done), 0);
    chk("rst_z",     int'(z), 0);
    chk("rst_in0",   int'(alu_in0), 0);
    chk("rst_op",    int'(alu_op), 0);
    for (int i = 0; i < 4; i++) check_reg(i, 0, "rst_reg");

    // Load immediate into R1
    send(11, 1, 0, 8'h5A, 1);
    wait_done(lat, ill, 0);
    chk("t1_latency", lat, 3);
    chk("t1_illegal", int'(ill), 0);
    @(posedge clk); #1;
    check_reg(1, 8'h5A, "t1_r1");
    chk("t1_z", int'(z), 0);

    // Subtract equal values, then increment
    send(11, 2, 0, 8'h5A, 1); wait_done(lat, ill, 0); @(posedge clk); #1;
    send(4, 1, 2, 0, 0);      wait_done(lat, ill, 0); @(posedge clk); #1;
    check_reg(1, 8'h00, "t2_sub_r1");
    chk("t2_sub_z", int'(z), 1);
    send(9, 1, 0, 0, 0);      wait_done(lat, ill, 0); @(posedge clk); #1;
    check_reg(1, 8'h01, "t2_inc_r1");
    chk("t2_inc_z", int'(z), 0);

    // Increment wraps, then self-rewrite leaves Z alone
    send(11, 0, 0, 8'hFF, 1); wait_done(lat, ill, 0); @(posedge clk); #1;
    send(9, 0, 0, 0, 0);      wait_done(lat, ill, 0); @(posedge clk); #1;
    check_reg(0, 8'h00, "t3_wrap_r0");
    chk("t3_wrap_z", int'(z), 1);
    send(10, 0, 0, 8'h33, 1); wait_done(lat, ill, 0); @(posedge clk); #1;
    check_reg(0, 8'h00, "t3_self_r0");
    chk("t3_self_z", int'(z), 1);

    // Illegal opcode
    send(14, 3, 1, 8'h77, 1);
    wait_done(lat, ill, 0);
    chk("t4_done_ill", int'(ill), 1);
    @(posedge clk); #1;
    check_reg(0, 8'h00, "t4_r0");
    check_reg(1, 8'h01, "t4_r1");
    check_reg(2, 8'h5A, "t4_r2");
    check_reg(3, 8'h00, "t4_r3");
    chk("t4_z", int'(z), 1);

    // Continuous valid, dependent pair
    present(11, 3, 0, 8'h10, 1);
    accept(t1);
    present(0, 3, 3, 0, 0);
    accept(t2);
    instr_valid = 1'b0;
    chk("t5_spacing", t2 - t1, 4);
    wait_done(lat, ill, 0);
    @(posedge clk); #1;
    check_reg(3, 8'h20, "t5_r3");
    chk("t5_z", int'(z), 0);

    // Reset during EXEC
    send(5, 3, 2, 0, 0);
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_done", int'(done), 0);
      @(posedge clk); #1;
    end
    check_reg(3, 8'h00, "t6_r3");
    chk("t6_z", int'(z), 0);
    chk("t6_ready", int'(instr_ready), 1);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) begin
        dbg_sel = AW'($urandom);
        @(posedge clk); #1;
      end
      send($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 255), $urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        do_reset();
      end else begin
        wait_done(lat, ill, 1);
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
